// File: rtl/bus_arbiter4x64.sv
// Round-robin arbiter granting one 64-bit target port to one of four requesters,
// holding the grant for a whole multi-beat transaction with a stall watchdog.

module mux4_1x64 (
  input  logic [1:0]       i_sel,
  input  logic [3:0][63:0] i_data,
  output logic [63:0]      o_data
);
  assign o_data = i_data[i_sel];
endmodule

module bus_arbiter4x64 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [3:0][63:0] in,
  output logic [63:0]      out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ack,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             timeout_err
);

  // Counter is kept at least one bit wide so TIMEOUT=0 (watchdog off) still elaborates.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout_err;

  state_t           w_state_nx;
  logic [3:0]       w_gnt_nx;
  logic [1:0]       w_sel_nx;
  logic [1:0]       w_ptr_nx;
  logic [CNT_W-1:0] w_stall_nx;
  logic             w_timeout_nx;
  logic             w_pick_found;
  logic [1:0]       w_pick_idx;
  logic             w_xfer;
  logic             w_release;

  mux4_1x64 u_mux (
    .i_sel  (r_sel),
    .i_data (in),
    .o_data (out)
  );

  assign out_valid   = (r_state == ST_BUSY) && req[r_sel];
  assign w_xfer      = out_valid && out_ready;
  assign ack         = r_gnt & {4{w_xfer}};
  assign gnt         = r_gnt;
  assign sel         = r_sel;
  assign timeout_err = r_timeout_err;

  // First requester at or after the round-robin pointer, wrapping mod 4.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = r_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!w_pick_found && req[r_ptr + 2'(k)]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = r_ptr + 2'(k);
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_sel_nx     = r_sel;
    w_ptr_nx     = r_ptr;
    w_stall_nx   = r_stall_cnt;
    w_timeout_nx = 1'b0;
    w_release    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nx = ST_BUSY;
          w_gnt_nx   = 4'(1) << w_pick_idx;
          w_sel_nx   = w_pick_idx;
          w_stall_nx = '0;
        end
      end
      ST_BUSY: begin
        // Release causes are prioritised: final beat, withdrawal, then watchdog.
        if (w_xfer && last[r_sel]) begin
          w_release = 1'b1;
        end else if (!req[r_sel]) begin
          w_release = 1'b1;
        end else if ((TIMEOUT != 0) && (r_stall_cnt == STALL_MAX) && !w_xfer) begin
          w_release    = 1'b1;
          w_timeout_nx = 1'b1;
        end else begin
          w_stall_nx = w_xfer ? '0 : r_stall_cnt + CNT_W'(1);
        end

        if (w_release) begin
          w_state_nx = ST_IDLE;
          w_gnt_nx   = '0;
          w_stall_nx = '0;
          w_ptr_nx   = r_sel + 2'd1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_gnt         <= '0;
      r_sel         <= '0;
      r_ptr         <= '0;
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_gnt         <= w_gnt_nx;
      r_sel         <= w_sel_nx;
      r_ptr         <= w_ptr_nx;
      r_stall_cnt   <= w_stall_nx;
      r_timeout_err <= w_timeout_nx;
    end
  end

endmodule

// File: tb/tb_bus_arbiter4x64.sv
// Self-checking bench for bus_arbiter4x64: vector table, directed corner-case
// sequences, and randomized traffic against a transaction-level reference model.

module tb_bus_arbiter4x64;

  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       req;
  logic [3:0]       last;
  logic [3:0][63:0] in_data;
  logic [63:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       ack;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter4x64 #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .last        (last),
    .in          (in_data),
    .out         (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ack         (ack),
    .gnt         (gnt),
    .sel         (sel),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 4; i++) in_data[i] = {$urandom, $urandom};
  endtask

  // Transaction-level reference: who owns the bus, where the rotation starts,
  // and how many consecutive stalled cycles the owner has accumulated.
  int m_owner;   // -1 when the bus is free
  int m_sel;
  int m_ptr;
  int m_stalls;
  bit m_terr;

  task automatic model_reset();
    m_owner  = -1;
    m_sel    = 0;
    m_ptr    = 0;
    m_stalls = 0;
    m_terr   = 1'b0;
  endtask

  task automatic model_check(input string tag);
    logic [3:0] e_gnt;
    logic       e_valid;
    e_gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    e_valid = (m_owner >= 0) && req[m_owner];
    check({tag, ".gnt"}, 64'(gnt), 64'(e_gnt));
    check({tag, ".sel"}, 64'(sel), 64'(m_sel));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
    check({tag, ".ack"}, 64'(ack), 64'((e_valid && out_ready) ? e_gnt : 4'b0));
    check({tag, ".timeout_err"}, 64'(timeout_err), 64'(m_terr));
    check({tag, ".out"}, out_data, in_data[m_sel]);
  endtask

  task automatic model_step();
    bit taken, done;
    if (m_owner < 0) begin
      m_terr = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner  = (m_ptr + k) % 4;
          m_sel    = m_owner;
          m_stalls = 0;
        end
      end
    end else begin
      taken  = req[m_owner] && out_ready;
      done   = 1'b0;
      m_terr = 1'b0;
      if (taken && last[m_owner]) done = 1'b1;
      else if (!req[m_owner]) done = 1'b1;
      else if (TIMEOUT > 0 && !taken && m_stalls + 1 == TIMEOUT) begin
        done   = 1'b1;
        m_terr = 1'b1;
      end else m_stalls = taken ? 0 : m_stalls + 1;
      if (done) begin
        m_ptr    = (m_owner + 1) % 4;
        m_owner  = -1;
        m_stalls = 0;
      end
    end
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;
    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    logic       e_valid;
    logic [3:0] e_ack;
    logic       e_terr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000, 1'b0};
    vecs[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0};
    vecs[7]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0};
    vecs[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b0};
    vecs[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0};

    reset_n   = 1'b0;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;
    randomize_data();
    #3;

    // Reset state plus single transaction to requester 2, then pointer at 3.
    apply_reset();
    for (int v = 0; v < 11; v++) begin
      req       = vecs[v].req;
      last      = vecs[v].last;
      out_ready = vecs[v].ready;
      randomize_data();
      sample();
      check($sformatf("vec%0d.gnt", v), 64'(gnt), 64'(vecs[v].e_gnt));
      check($sformatf("vec%0d.sel", v), 64'(sel), 64'(vecs[v].e_sel));
      check($sformatf("vec%0d.out_valid", v), 64'(out_valid), 64'(vecs[v].e_valid));
      check($sformatf("vec%0d.ack", v), 64'(ack), 64'(vecs[v].e_ack));
      check($sformatf("vec%0d.timeout_err", v), 64'(timeout_err), 64'(vecs[v].e_terr));
      check($sformatf("vec%0d.out", v), out_data, in_data[sel]);
      tick();
    end

    // Round-robin from reset: 0,1,2,3,0 with an idle cycle between grants.
    apply_reset();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sample();
      check($sformatf("rr%0d.gnt", c), 64'(gnt), 64'((c % 2 == 0) ? 4'b0 : 4'(1 << ((c / 2) % 4))));
      tick();
    end

    // Multi-beat: three beats from requester 0 with out_ready toggling.
    apply_reset();
    req = 4'b0001; last = 4'b0000; out_ready = 1'b0;
    sample();
    check("mb.idle_gnt", 64'(gnt), 64'(4'b0000));
    tick();
    for (int b = 0; b < 5; b++) begin
      out_ready = (b % 2 == 0);
      last      = (b == 4) ? 4'b0001 : 4'b0000;
      randomize_data();
      sample();
      check($sformatf("mb%0d.gnt", b), 64'(gnt), 64'(4'b0001));
      check($sformatf("mb%0d.ack", b), 64'(ack), 64'((b % 2 == 0) ? 4'b0001 : 4'b0000));
      check($sformatf("mb%0d.out", b), out_data, in_data[0]);
      tick();
    end
    req = 4'b0000;
    sample();
    check("mb.released_gnt", 64'(gnt), 64'(4'b0000));
    tick();

    // Withdrawal: requester 1 drops its request without a final beat.
    apply_reset();
    req = 4'b0010; last = 4'b0000; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      sample();
      check($sformatf("wd%0d.gnt", c), 64'(gnt), 64'(4'b0010));
      tick();
    end
    req = 4'b0000;
    sample();
    check("wd.drop_valid", 64'(out_valid), 64'(1'b0));
    tick();
    req = 4'b1111;
    sample();
    check("wd.idle_gnt", 64'(gnt), 64'(4'b0000));
    check("wd.no_timeout", 64'(timeout_err), 64'(1'b0));
    tick();
    sample();
    check("wd.next_gnt_ptr2", 64'(gnt), 64'(4'b0100));
    tick();

    // Watchdog: requester 3 stalls; release after TIMEOUT busy cycles.
    apply_reset();
    req = 4'b1000; last = 4'b0000; out_ready = 1'b0;
    tick();
    for (int c = 0; c < TIMEOUT; c++) begin
      sample();
      check($sformatf("to%0d.gnt", c), 64'(gnt), 64'(4'b1000));
      check($sformatf("to%0d.timeout_err", c), 64'(timeout_err), 64'(1'b0));
      tick();
    end
    req = 4'b1001;
    sample();
    check("to.release_gnt", 64'(gnt), 64'(4'b0000));
    check("to.pulse", 64'(timeout_err), 64'(1'b1));
    tick();
    sample();
    check("to.pulse_end", 64'(timeout_err), 64'(1'b0));
    check("to.next_gnt_ptr0", 64'(gnt), 64'(4'b0001));
    tick();

    // Asynchronous reset in the middle of a busy transaction.
    apply_reset();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    last = 4'b0000; out_ready = 1'b0;
    #1;
    check("ar.pre_gnt", 64'(gnt), 64'(4'b0100));
    #1;
    reset_n = 1'b0;
    #1;
    check("ar.gnt", 64'(gnt), 64'(4'b0000));
    check("ar.out_valid", 64'(out_valid), 64'(1'b0));
    check("ar.sel", 64'(sel), 64'(2'd0));
    tick();
    reset_n = 1'b1;
    model_reset();
    last = 4'b1111; out_ready = 1'b1;
    sample();
    check("ar.idle_gnt", 64'(gnt), 64'(4'b0000));
    tick();
    sample();
    check("ar.first_gnt", 64'(gnt), 64'(4'b0001));
    tick();

    // Randomized traffic against the reference model, with occasional resets.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        model_reset();
      end
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
      last = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      case ((c / 250) % 3)
        0:       out_ready = ($urandom_range(0, 19) == 0);
        1:       out_ready = ($urandom_range(0, 1) == 0);
        default: out_ready = ($urandom_range(0, 9) != 0);
      endcase
      randomize_data();
      sample();
      model_check($sformatf("rnd%0d", c));
      model_step();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
